// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the multi_port_ram_init block.
//   ram_state_t   - clear-sequencer FSM state
//   RD_FIRST /
//   WR_FIRST_MODE - values for the WR_FIRST parameter
//   depth_f       - number of words for a given address width
package ram_pkg;

    typedef enum logic {S_INIT, S_RUN} ram_state_t;

    localparam int unsigned RD_FIRST      = 0;
    localparam int unsigned WR_FIRST_MODE = 1;

    function automatic int unsigned depth_f(input int unsigned a_width);
        return 32'd1 << a_width;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: clear sequencer for multi_port_ram_init.
// After reset it walks every address once, asking the RAM to write zero,
// then parks in S_RUN.
// Ports:
//   i_clk        - clock
//   i_reset      - synchronous active-high reset, restarts the clear
//   o_init_we    - write zero to o_init_add this cycle
//   o_init_add   - address being cleared
//   o_init_busy  - high while clearing (and during any reset cycle)
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int unsigned A_WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    output logic               o_init_we,
    output logic [A_WIDTH-1:0] o_init_add,
    output logic               o_init_busy
);

    // One extra counter bit keeps the terminal compare from wrapping.
    localparam logic [A_WIDTH:0] LAST = (A_WIDTH + 1)'(depth_f(A_WIDTH) - 1);

    ram_state_t       r_state;
    ram_state_t       w_state_next;
    logic [A_WIDTH:0] r_cnt;
    logic [A_WIDTH:0] w_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_init_we    = 1'b0;
        case (r_state)
            S_INIT: begin
                o_init_we  = ~i_reset;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    assign o_init_add  = r_cnt[A_WIDTH-1:0];
    assign o_init_busy = i_reset | (r_state == S_INIT);

endmodule

// File: rtl/multi_port_ram_init.sv
// multi_port_ram_init: register-file RAM, one write port and N_RD read ports.
// Each read port is asynchronous or registered (SYNC_MASK bit), registered
// ports follow the WR_FIRST read-during-write policy. A clear sequencer
// zeroes every word after reset; outputs read 0 while it runs.
// Optional feature: define RAM_BYTE_WE_EN to add per-byte write enables (be).
// Ports:
//   clk       - clock
//   reset     - synchronous active-high reset, starts the clear
//   we        - write enable (ignored while init_busy)
//   be        - byte enables, RAM_BYTE_WE_EN builds only
//   w_add     - write address
//   w_data    - write data
//   r_add     - packed read addresses, port i at [i*A_WIDTH +: A_WIDTH]
//   r_data    - packed read data, port i at [i*D_WIDTH +: D_WIDTH]
//   init_busy - high while the clear sequence runs
module multi_port_ram_init
    import ram_pkg::*;
#(
    parameter int unsigned     A_WIDTH   = 3,
    parameter int unsigned     D_WIDTH   = 8,
    parameter int unsigned     N_RD      = 2,
    parameter logic [N_RD-1:0] SYNC_MASK = 2'b10,
    parameter int unsigned     WR_FIRST  = RD_FIRST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
`ifdef RAM_BYTE_WE_EN
    input  logic [D_WIDTH/8-1:0]      be,
`endif
    input  logic [A_WIDTH-1:0]        w_add,
    input  logic [D_WIDTH-1:0]        w_data,
    input  logic [N_RD*A_WIDTH-1:0]   r_add,
    output logic [N_RD*D_WIDTH-1:0]   r_data,
    output logic                      init_busy
);

    localparam int unsigned DEPTH = depth_f(A_WIDTH);

    if (N_RD < 1 || N_RD > 8) begin : g_bad_nrd
        $error("N_RD must be in 1..8");
    end
`ifdef RAM_BYTE_WE_EN
    if (D_WIDTH % 8 != 0) begin : g_bad_dw
        $error("D_WIDTH must be a multiple of 8 when byte enables are used");
    end
`endif

    logic               w_init_we;
    logic [A_WIDTH-1:0] w_init_add;
    logic               w_busy;
    logic               w_user_we;
    logic [D_WIDTH-1:0] w_wr_word;
    logic [D_WIDTH-1:0] r_mem [DEPTH];

    ram_init_seq #(
        .A_WIDTH (A_WIDTH)
    ) u_init_seq (
        .i_clk       (clk),
        .i_reset     (reset),
        .o_init_we   (w_init_we),
        .o_init_add  (w_init_add),
        .o_init_busy (w_busy)
    );

    assign init_busy = w_busy;
    assign w_user_we = we & ~w_busy;

    // Word as it will be stored; also the write-first forward value.
    always_comb begin
        w_wr_word = w_data;
`ifdef RAM_BYTE_WE_EN
        for (int k = 0; k < int'(D_WIDTH / 8); k++) begin
            if (!be[k]) begin
                w_wr_word[8*k +: 8] = r_mem[w_add][8*k +: 8];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_add] <= '0;
        end else if (w_user_we) begin
            r_mem[w_add] <= w_wr_word;
        end
    end

    for (genvar i = 0; i < int'(N_RD); i++) begin : g_rd
        logic [A_WIDTH-1:0] w_ra;
        assign w_ra = r_add[i*A_WIDTH +: A_WIDTH];

        if (SYNC_MASK[i]) begin : g_sync
            logic [D_WIDTH-1:0] r_rd;
            // Non-blocking array write means r_mem here is still the old word.
            always_ff @(posedge clk) begin
                if (reset || w_busy) begin
                    r_rd <= '0;
                end else if (WR_FIRST == WR_FIRST_MODE && w_user_we && w_add == w_ra) begin
                    r_rd <= w_wr_word;
                end else begin
                    r_rd <= r_mem[w_ra];
                end
            end
            assign r_data[i*D_WIDTH +: D_WIDTH] = w_busy ? '0 : r_rd;
        end else begin : g_async
            assign r_data[i*D_WIDTH +: D_WIDTH] = w_busy ? '0 : r_mem[w_ra];
        end
    end

endmodule

// File: tb/tb_multi_port_ram_init.sv
module tb_multi_port_ram_init;

    localparam int unsigned AW = 3;
`ifdef RAM_BYTE_WE_EN
    localparam int unsigned DW = 16;
`else
    localparam int unsigned DW = 8;
`endif
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            we     = 1'b0;
    logic [BW-1:0]   be     = '1;
    logic [AW-1:0]   w_add  = '0;
    logic [DW-1:0]   w_data = '0;
    logic [NR*AW-1:0] r_add = '0;
    logic [NR*DW-1:0] rd_a;
    logic [NR*DW-1:0] rd_b;
    logic            busy_a;
    logic            busy_b;

    always #5 clk = ~clk;

    // Read-first instance
    multi_port_ram_init #(
        .A_WIDTH   (AW),
        .D_WIDTH   (DW),
        .N_RD      (NR),
        .SYNC_MASK (2'b10),
        .WR_FIRST  (0)
    ) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
`ifdef RAM_BYTE_WE_EN
        .be        (be),
`endif
        .w_add     (w_add),
        .w_data    (w_data),
        .r_add     (r_add),
        .r_data    (rd_a),
        .init_busy (busy_a)
    );

    // Write-first instance
    multi_port_ram_init #(
        .A_WIDTH   (AW),
        .D_WIDTH   (DW),
        .N_RD      (NR),
        .SYNC_MASK (2'b10),
        .WR_FIRST  (1)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
`ifdef RAM_BYTE_WE_EN
        .be        (be),
`endif
        .w_add     (w_add),
        .w_data    (w_data),
        .r_add     (r_add),
        .r_data    (rd_b),
        .init_busy (busy_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: array contents, clear progress, expected sync outputs.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init = 1'b0;
    int            m_cnt  = 0;
    logic [DW-1:0] m_sync_a = '0;
    logic [DW-1:0] m_sync_b = '0;

    function automatic logic [DW-1:0] stored_word();
        logic [DW-1:0] v;
        v = m_mem[w_add];
        for (int k = 0; k < int'(BW); k++) begin
            if (be[k]) v[8*k +: 8] = w_data[8*k +: 8];
        end
        return v;
    endfunction

    // Inputs are set at the falling edge; check just after, then advance the model.
    task automatic tick();
        logic          bsy;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] nw;
        #1;
        bsy = reset || m_init;
        ra0 = r_add[0 +: AW];
        ra1 = r_add[AW +: AW];
        check("busy_a", 32'(busy_a), 32'(bsy));
        check("busy_b", 32'(busy_b), 32'(bsy));
        check("a_port0", 32'(rd_a[0 +: DW]), bsy ? 32'd0 : 32'(m_mem[ra0]));
        check("b_port0", 32'(rd_b[0 +: DW]), bsy ? 32'd0 : 32'(m_mem[ra0]));
        check("a_port1", 32'(rd_a[DW +: DW]), bsy ? 32'd0 : 32'(m_sync_a));
        check("b_port1", 32'(rd_b[DW +: DW]), bsy ? 32'd0 : 32'(m_sync_b));
        if (reset) begin
            m_init   = 1'b1;
            m_cnt    = 0;
            m_sync_a = '0;
            m_sync_b = '0;
        end else if (m_init) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == int'(DEPTH)) m_init = 1'b0;
            m_sync_a = '0;
            m_sync_b = '0;
        end else begin
            nw = stored_word();
            if (we && w_add == ra1) begin
                m_sync_a = m_mem[ra1];
                m_sync_b = nw;
            end else begin
                m_sync_a = m_mem[ra1];
                m_sync_b = m_mem[ra1];
            end
            if (we) m_mem[w_add] = nw;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);

        // Clear sequence, with a write attempted on the 2nd init cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            if (n == 1) begin
                we = 1'b1; w_add = 3'd3; w_data = DW'('hAA);
            end else begin
                we = 1'b0;
            end
            tick();
            n++;
        end
        we = 1'b0;
        check("clear_len", 32'(n), 32'(DEPTH));
        for (int a = 0; a < int'(DEPTH); a++) begin
            r_add = {AW'(a), AW'(a)};
            tick();
        end
        r_add = {AW'(3), AW'(3)};
        #1 check("init_wr_ignored", 32'(rd_a[0 +: DW]), 32'd0);
        tick();

        // Latency: async same cycle, sync one cycle later
        we = 1'b1; w_add = 3'd2; w_data = DW'('h5C); r_add = '0;
        tick();
        we = 1'b0; r_add = {AW'(2), AW'(2)};
        #1 check("lat_async", 32'(rd_a[0 +: DW]), 32'h5C);
        tick();
        #1 check("lat_sync", 32'(rd_a[DW +: DW]), 32'h5C);
        tick();

        // Collision on the sync port
        we = 1'b1; w_add = 3'd4; w_data = DW'('h11);
        tick();
        w_data = DW'('h22); r_add = {AW'(4), AW'(0)};
        tick();
        we = 1'b0;
        #1;
        check("coll_rd_first", 32'(rd_a[DW +: DW]), 32'h11);
        check("coll_wr_first", 32'(rd_b[DW +: DW]), 32'h22);
        tick();

        // Reset reasserted on init cycle 5
        we = 1'b1; w_add = 3'd6; w_data = DW'('h77);
        tick();
        we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_len", 32'(n), 32'(DEPTH));
        r_add = {AW'(6), AW'(6)};
        #1 check("rst_mid_cleared", 32'(rd_a[0 +: DW]), 32'd0);
        tick();

`ifdef RAM_BYTE_WE_EN
        we = 1'b1; w_add = 3'd1; w_data = DW'('hFFFF); be = '1;
        tick();
        w_data = DW'('h1234); be = BW'(1);
        tick();
        we = 1'b0; be = '1; r_add = {AW'(1), AW'(1)};
        #1 check("byte_we", 32'(rd_a[0 +: DW]), 32'hFF34);
        tick();
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(0, 79) == 0);
            we     = 1'($urandom);
            w_add  = AW'($urandom);
            w_data = DW'($urandom);
            r_add  = (NR*AW)'($urandom);
`ifdef RAM_BYTE_WE_EN
            be     = BW'($urandom);
`endif
            tick();
        end
        reset = 1'b0; we = 1'b0;
        for (int c = 0; c < int'(DEPTH) + 2; c++) begin
            r_add = (NR*AW)'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
